// File: rtl/agc_gain_sequencer.sv
// AGC gain sequencer: steps per-channel gain codes from power measurements
// and issues one register write per update to the downstream SPI/parallel stage.
module agc_gain_sequencer #(
  parameter int unsigned GAIN_W      = 6,
  parameter int unsigned PWR_W       = 12,
  parameter int unsigned GAIN_INIT   = 32,
  parameter int unsigned GAIN_MAX    = 63,
  parameter int unsigned STEP        = 1,
  parameter logic [7:0]  GAIN_ADDR   = 8'h02,
  parameter int unsigned SETTLE_CYC  = 256,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        control_mode,
  input  logic              pwr_valid,
  input  logic [PWR_W-1:0]  pwr_data,
  input  logic              pwr_chan,
  input  logic [PWR_W-1:0]  target,
  input  logic [PWR_W-1:0]  hyst,
  output logic              spi_start,
  input  logic              spi_done,
  output logic [7:0]        spi_mode,
  output logic              sig_R1W0,
  output logic [7:0]        spi_dataA,
  output logic [7:0]        spi_dataB,
  output logic              channel,
  output logic [GAIN_W-1:0] gain_a,
  output logic [GAIN_W-1:0] gain_b,
  output logic [1:0]        sat,
  output logic              timeout_err,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_ISSUE, S_WAIT_DONE, S_SETTLE} state_t;

  state_t             state_q, state_d;
  logic [PWR_W-1:0]   pwr_q, pwr_d;
  logic               chan_q, chan_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAIN_W-1:0]  gain_a_q, gain_a_d, gain_b_q, gain_b_d;
  logic               spi_start_q, spi_start_d;
  logic [7:0]         spi_mode_q, spi_mode_d;
  logic [7:0]         spi_data_a_q, spi_data_a_d, spi_data_b_q, spi_data_b_d;
  logic               channel_q, channel_d;
  logic [1:0]         sat_q, sat_d;
  logic               timeout_err_q, timeout_err_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               busy_q, busy_d;

  // Power comparison widened by one bit so target+hyst and pwr+hyst cannot wrap
  logic [PWR_W:0]     pwr_x, tgt_x, hi_x, lo_x;
  logic               step_dn, step_up;
  assign pwr_x   = {1'b0, pwr_q};
  assign tgt_x   = {1'b0, target};
  assign hi_x    = tgt_x + {1'b0, hyst};
  assign lo_x    = pwr_x + {1'b0, hyst};
  assign step_dn = (pwr_x > hi_x);
  assign step_up = (lo_x < tgt_x);

  // Saturating candidate gain for the latched channel
  logic [GAIN_W-1:0]  cur_gain, gain_dn, gain_up, new_gain;
  logic [GAIN_W:0]    up_sum;
  assign cur_gain = chan_q ? gain_b_q : gain_a_q;
  assign gain_dn  = (cur_gain >= GAIN_W'(STEP)) ? (cur_gain - GAIN_W'(STEP)) : '0;
  assign up_sum   = {1'b0, cur_gain} + (GAIN_W+1)'(STEP);
  assign gain_up  = (up_sum > (GAIN_W+1)'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : up_sum[GAIN_W-1:0];
  assign new_gain = step_dn ? gain_dn : gain_up;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    pwr_d         = pwr_q;
    chan_d        = chan_q;
    par_d         = par_q;
    cnt_d         = cnt_q;
    gain_a_d      = gain_a_q;
    gain_b_d      = gain_b_q;
    spi_start_d   = 1'b0;
    spi_mode_d    = spi_mode_q;
    spi_data_a_d  = spi_data_a_q;
    spi_data_b_d  = spi_data_b_q;
    channel_d     = channel_q;
    sat_d         = sat_q;
    timeout_err_d = timeout_err_q;
    drop_cnt_d    = drop_cnt_q;

    if (pwr_valid && (state_q != S_IDLE) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && pwr_valid) begin
          pwr_d   = pwr_data;
          chan_d  = pwr_chan;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!step_dn && !step_up) begin
          state_d = S_IDLE;
        end else if (new_gain == cur_gain) begin
          sat_d[chan_q] = 1'b1;
          state_d       = S_IDLE;
        end else begin
          if (chan_q) gain_b_d = new_gain;
          else        gain_a_d = new_gain;
          sat_d[chan_q] = 1'b0;
          // Transaction payload lands together with the gain so it is valid in ISSUE
          spi_mode_d    = GAIN_ADDR;
          spi_data_a_d  = 8'(gain_a_d);
          spi_data_b_d  = 8'(gain_b_d);
          channel_d     = chan_q;
          par_d         = (control_mode == 2'b10);
          spi_start_d   = (control_mode != 2'b10);
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = par_q ? S_SETTLE : S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (spi_done) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pwr_q         <= '0;
      chan_q        <= 1'b0;
      par_q         <= 1'b0;
      cnt_q         <= '0;
      gain_a_q      <= GAIN_W'(GAIN_INIT);
      gain_b_q      <= GAIN_W'(GAIN_INIT);
      spi_start_q   <= 1'b0;
      spi_mode_q    <= '0;
      spi_data_a_q  <= '0;
      spi_data_b_q  <= '0;
      channel_q     <= 1'b0;
      sat_q         <= '0;
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwr_q         <= pwr_d;
      chan_q        <= chan_d;
      par_q         <= par_d;
      cnt_q         <= cnt_d;
      gain_a_q      <= gain_a_d;
      gain_b_q      <= gain_b_d;
      spi_start_q   <= spi_start_d;
      spi_mode_q    <= spi_mode_d;
      spi_data_a_q  <= spi_data_a_d;
      spi_data_b_q  <= spi_data_b_d;
      channel_q     <= channel_d;
      sat_q         <= sat_d;
      timeout_err_q <= timeout_err_d;
      drop_cnt_q    <= drop_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign spi_start   = spi_start_q;
  assign spi_mode    = spi_mode_q;
  assign sig_R1W0    = 1'b0;
  assign spi_dataA   = spi_data_a_q;
  assign spi_dataB   = spi_data_b_q;
  assign channel     = channel_q;
  assign gain_a      = gain_a_q;
  assign gain_b      = gain_b_q;
  assign sat         = sat_q;
  assign timeout_err = timeout_err_q;
  assign drop_cnt    = drop_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Self-checking bench for agc_gain_sequencer with a transaction scoreboard.
module tb_agc_gain_sequencer;

  localparam int SETTLE  = 256;
  localparam int TIMEOUT = 4096;

  logic        main_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  control_mode = 2'b00;
  logic        pwr_valid = 1'b0;
  logic [11:0] pwr_data = '0;
  logic        pwr_chan = 1'b0;
  logic [11:0] target = 12'd1000;
  logic [11:0] hyst = 12'd50;
  logic        spi_start;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_mode;
  logic        sig_R1W0;
  logic [7:0]  spi_dataA, spi_dataB;
  logic        channel;
  logic [5:0]  gain_a, gain_b;
  logic [1:0]  sat;
  logic        timeout_err;
  logic [7:0]  drop_cnt;
  logic        busy;

  agc_gain_sequencer dut (
    .main_clk(main_clk), .reset(reset), .enable(enable), .control_mode(control_mode),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_chan(pwr_chan), .target(target),
    .hyst(hyst), .spi_start(spi_start), .spi_done(spi_done), .spi_mode(spi_mode),
    .sig_R1W0(sig_R1W0), .spi_dataA(spi_dataA), .spi_dataB(spi_dataB), .channel(channel),
    .gain_a(gain_a), .gain_b(gain_b), .sat(sat), .timeout_err(timeout_err),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 main_clk = ~main_clk;

  int cyc = 0;
  always @(posedge main_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic       ch;
    logic [5:0] ga;
    logic [5:0] gb;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state
  int         m_ga = 32, m_gb = 32;
  logic [1:0] m_sat = 2'b00;
  int         tgt = 1000, hys = 50;

  bit done_en  = 1'b1;
  int done_dly = 10;

  // SPI stage stand-in: answers each start with a one-cycle done after done_dly cycles
  initial begin
    forever begin
      @(negedge main_clk);
      if (reset && spi_start && done_en) begin
        repeat (done_dly) @(posedge main_clk);
        #1 spi_done = 1'b1;
        @(posedge main_clk);
        #1 spi_done = 1'b0;
      end
    end
  end

  // Transaction monitor: every spi_start must match the oldest scoreboard entry
  always @(negedge main_clk) begin
    if (reset && spi_start) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_spi_start: got start at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        vectors++;
        if (cyc !== mon_e.cyc) begin
          miscompares++;
          $display("FAIL start_latency: got cycle %0d, expected %0d", cyc, mon_e.cyc);
        end
        vectors++;
        if ({spi_mode, sig_R1W0, channel, spi_dataA, spi_dataB} !==
            {8'h02, 1'b0, mon_e.ch, 2'b00, mon_e.ga, 2'b00, mon_e.gb}) begin
          miscompares++;
          $display("FAIL txn_payload: got mode=%h rw=%b ch=%b A=%h B=%h, expected mode=02 rw=0 ch=%b A=%h B=%h",
                   spi_mode, sig_R1W0, channel, spi_dataA, spi_dataB, mon_e.ch,
                   {2'b00, mon_e.ga}, {2'b00, mon_e.gb});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_eval(input int p, input bit ch, output bit txn);
    int g, ng;
    txn = 1'b0;
    g = ch ? m_gb : m_ga;
    if (p > tgt + hys)      ng = (g > 0)  ? g - 1 : 0;
    else if (p + hys < tgt) ng = (g < 63) ? g + 1 : 63;
    else return;
    if (ng == g) begin
      m_sat[ch] = 1'b1;
      return;
    end
    if (ch) m_gb = ng;
    else    m_ga = ng;
    m_sat[ch] = 1'b0;
    txn = 1'b1;
  endtask

  task automatic pulse(input logic [11:0] d, input logic ch, output int c);
    @(negedge main_clk);
    pwr_data  = d;
    pwr_chan  = ch;
    pwr_valid = 1'b1;
    @(posedge main_clk);
    #1 pwr_valid = 1'b0;
    c = cyc;
  endtask

  task automatic wait_idle(input int budget, input int c, output int el, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge main_clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    el = cyc - c;
  endtask

  task automatic push_exp(input int c, input bit ch);
    exp_t e;
    e.cyc = c + 1;
    e.ch  = ch;
    e.ga  = 6'(m_ga);
    e.gb  = 6'(m_gb);
    sb_q.push_back(e);
  endtask

  task automatic run_sample(input int p, input bit ch, input bit par, input string name);
    bit txn, ok;
    int c, el, exp_el;
    model_eval(p, ch, txn);
    pulse(12'(p), ch, c);
    if (txn && !par) push_exp(c, ch);
    wait_idle(6000, c, el, ok);
    exp_el = !txn ? 1 : (par ? 2 + SETTLE : (done_en ? 2 + done_dly + SETTLE : 2 + TIMEOUT + SETTLE));
    vectors++;
    if (!ok || el != exp_el) begin
      miscompares++;
      $display("FAIL %s_busy_len: got %0d cycles (idle=%0b), expected %0d", name, el, ok, exp_el);
    end
    vectors++;
    if ({gain_a, gain_b, sat} !== {6'(m_ga), 6'(m_gb), m_sat}) begin
      miscompares++;
      $display("FAIL %s_gains: got a=%0d b=%0d sat=%b, expected a=%0d b=%0d sat=%b",
               name, gain_a, gain_b, sat, m_ga, m_gb, m_sat);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    vectors++;
    if ({spi_start, spi_mode, sig_R1W0, spi_dataA, spi_dataB, channel, sat, timeout_err, drop_cnt, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected all zero",
               {spi_start, spi_mode, sig_R1W0, spi_dataA, spi_dataB, channel, sat, timeout_err, drop_cnt, busy});
    end
    vectors++;
    if ({gain_a, gain_b} !== {6'd32, 6'd32}) begin
      miscompares++;
      $display("FAIL reset_gains: got a=%0d b=%0d, expected 32 32", gain_a, gain_b);
    end
    repeat (3) @(negedge main_clk);
    reset  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_step_down();
    done_en  = 1'b1;
    done_dly = 10;
    run_sample(1100, 1'b0, 1'b0, "step_down");
    vectors++;
    if ({gain_a, spi_dataA, spi_mode} !== {6'd31, 8'h1F, 8'h02}) begin
      miscompares++;
      $display("FAIL step_down_fields: got gain_a=%0d A=%h mode=%h, expected 31 1f 02", gain_a, spi_dataA, spi_mode);
    end
  endtask

  task automatic test_dead_band();
    run_sample(1040, 1'b1, 1'b0, "dead_hi");
    run_sample(960,  1'b1, 1'b0, "dead_lo");
    vectors++;
    if (gain_b !== 6'd32) begin
      miscompares++;
      $display("FAIL dead_band_gain_b: got %0d, expected 32", gain_b);
    end
  endtask

  task automatic test_saturation();
    done_dly = 1;
    for (int i = 0; i < 32; i++) run_sample(0, 1'b1, 1'b0, "sat_up");
    vectors++;
    if ({gain_b, sat[1]} !== {6'd63, 1'b1}) begin
      miscompares++;
      $display("FAIL sat_set: got gain_b=%0d sat1=%b, expected 63 1", gain_b, sat[1]);
    end
    run_sample(4000, 1'b1, 1'b0, "sat_clear");
    vectors++;
    if ({gain_b, sat[1]} !== {6'd62, 1'b0}) begin
      miscompares++;
      $display("FAIL sat_clear: got gain_b=%0d sat1=%b, expected 62 0", gain_b, sat[1]);
    end
  endtask

  task automatic test_parallel();
    control_mode = 2'b10;
    run_sample(1100, 1'b0, 1'b1, "parallel");
    vectors++;
    if ({gain_a, spi_dataA, spi_dataB} !== {6'd30, 8'h1E, 8'h3E}) begin
      miscompares++;
      $display("FAIL parallel_fields: got gain_a=%0d A=%h B=%h, expected 30 1e 3e", gain_a, spi_dataA, spi_dataB);
    end
    control_mode = 2'b00;
  endtask

  task automatic test_timeout_drops();
    bit txn, ok;
    int c, cd, el;
    enable = 1'b0;
    pulse(12'd1100, 1'b0, cd);
    vectors++;
    if ({busy, drop_cnt} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL disabled_ignore: got busy=%b drop=%0d, expected 0 0", busy, drop_cnt);
    end
    enable  = 1'b1;
    done_en = 1'b0;
    model_eval(1100, 1'b0, txn);
    pulse(12'd1100, 1'b0, c);
    if (txn) push_exp(c, 1'b0);
    repeat (5) @(negedge main_clk);
    for (int i = 0; i < 3; i++) pulse(12'd1100, 1'b1, cd);
    wait_idle(6000, c, el, ok);
    vectors++;
    if (!ok || el != 2 + TIMEOUT + SETTLE) begin
      miscompares++;
      $display("FAIL timeout_busy_len: got %0d (idle=%0b), expected %0d", el, ok, 2 + TIMEOUT + SETTLE);
    end
    vectors++;
    if ({timeout_err, drop_cnt, gain_a} !== {1'b1, 8'd3, 6'd29}) begin
      miscompares++;
      $display("FAIL timeout_drops: got terr=%b drop=%0d gain_a=%0d, expected 1 3 29", timeout_err, drop_cnt, gain_a);
    end
  endtask

  task automatic test_reset_mid();
    bit txn;
    int c;
    done_en = 1'b0;
    model_eval(1100, 1'b0, txn);
    pulse(12'd1100, 1'b0, c);
    if (txn) push_exp(c, 1'b0);
    repeat (20) @(negedge main_clk);
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({spi_start, spi_mode, sig_R1W0, spi_dataA, spi_dataB, channel, sat, timeout_err, drop_cnt, busy} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h, expected all zero",
               {spi_start, spi_mode, sig_R1W0, spi_dataA, spi_dataB, channel, sat, timeout_err, drop_cnt, busy});
    end
    m_ga  = 32;
    m_gb  = 32;
    m_sat = 2'b00;
    repeat (2) @(negedge main_clk);
    reset = 1'b1;
    @(negedge main_clk);
    vectors++;
    if ({gain_a, gain_b, busy} !== {6'd32, 6'd32, 1'b0}) begin
      miscompares++;
      $display("FAIL post_reset_state: got a=%0d b=%0d busy=%b, expected 32 32 0", gain_a, gain_b, busy);
    end
    done_en  = 1'b1;
    done_dly = 3;
    run_sample(1100, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_step_down();
    test_dead_band();
    test_saturation();
    test_parallel();
    test_timeout_drops();
    test_reset_mid();
    repeat (4) @(negedge main_clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/agc_gain_sequencer.md
# agc_gain_sequencer

Closed-loop AGC gain stepper that sits directly upstream of the SPI/parallel gain-interface stage. It consumes per-channel power measurements and compares each against a target with a hysteresis window. It steps a saturating 6-bit gain code per channel, then issues one write transaction (register address, channel, A/B data words, start pulse) to the SPI stage. It waits for that stage's stop/done indication and holds off further updates for a settle interval.

## Interface
- GAIN_W, 6, gain code width (parallel pins A0..A5 / B0..B5)
- PWR_W, 12, unsigned power-measurement width
- GAIN_INIT, 32, per-channel gain after reset
- GAIN_MAX, 63, upper gain limit; lower limit is 0
- STEP, 1, gain increment/decrement per update
- GAIN_ADDR, 8'h02, register address driven on spi_mode for gain writes
- SETTLE_CYC, 256, cycles of hold-off after each update
- TIMEOUT_CYC, 4096, max cycles to wait for spi_done

Ports:
- main_clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; assert async, deassert synchronised by integrator
- enable  in  1  loop enable
- control_mode  in  2  00/01 SPI path, 10 parallel path, 11 treated as 00
- pwr_valid  in  1  one-cycle strobe, pwr_data/pwr_chan valid
- pwr_data  in  PWR_W  measured power
- pwr_chan  in  1  0 = channel A, 1 = channel B
- target  in  PWR_W  power setpoint (static during operation)
- hyst  in  PWR_W  half-width of dead band
- spi_start  out  1  one-cycle transaction request to SPI stage
- spi_done  in  1  SPI stage stop/done level
- spi_mode  out  8  register address to SPI stage
- sig_R1W0  out  1  constant 0 (write)
- spi_dataA, spi_dataB  out  8  {2'b00, gain_a} / {2'b00, gain_b}
- channel  out  1  channel of the current transaction
- gain_a, gain_b  out  GAIN_W  current gain codes
- sat  out  2  sticky saturation flags {B,A}
- timeout_err  out  1  sticky SPI timeout flag
- drop_cnt  out  8  saturating count of pwr_valid strobes ignored while busy
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, EVAL, ISSUE, WAIT_DONE, SETTLE.
- IDLE: on enable && pwr_valid, latch pwr_data and pwr_chan, go EVAL. With enable low, stay in IDLE and ignore pwr_valid; it is not counted.
- EVAL: compare in PWR_W+1 bits, so there is no overflow.
  - If pwr > target+hyst: new = max(gain−STEP, 0).
  - If pwr+hyst < target: new = min(gain+STEP, GAIN_MAX).
  - Otherwise, no change and go IDLE.
  - If a step is required but new == gain (already at a limit): set sat[chan] and go IDLE with no transaction.
  - Otherwise write new into gain_a/gain_b, clear sat[chan], go ISSUE.
- ISSUE: load spi_mode=GAIN_ADDR, spi_dataA/B from the updated gains, channel=chan, sig_R1W0=0.
  - SPI path: spi_start=1 this cycle only, go WAIT_DONE.
  - Parallel path (control_mode=10): no spi_start, go SETTLE.
- WAIT_DONE: on spi_done=1, go SETTLE. After TIMEOUT_CYC cycles without spi_done, set timeout_err and go SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go IDLE.
- Any pwr_valid while busy is dropped and increments drop_cnt, which saturates at 255.
- Deasserting enable mid-sequence does not abort; the current transaction and settle complete, then the FSM stays in IDLE.
- control_mode is sampled in ISSUE only.
- sat, timeout_err and drop_cnt clear only on reset.

## Timing
- Reset values:
  - FSM IDLE; gain_a = gain_b = GAIN_INIT.
  - spi_start=0, spi_mode=0, spi_dataA=spi_dataB=0, channel=0, sig_R1W0=0.
  - sat=0, timeout_err=0, drop_cnt=0, busy=0.
- Reset mid-operation: all of the above take effect immediately (async), and spi_start drops the same instant.
- Latency: pwr_valid sampled at edge N.
  - EVAL during cycle N+1.
  - gain_x, spi_mode, spi_data and channel updated and spi_start high during cycle N+2.
- Outputs are registered and held stable from ISSUE until the next ISSUE.
- spi_done must be sampled only in WAIT_DONE. A spi_done that is already high on WAIT_DONE entry completes in 1 cycle.
- SETTLE lasts exactly SETTLE_CYC cycles. The next pwr_valid is accepted on the first IDLE cycle.
- busy rises the cycle after pwr_valid is accepted and falls on IDLE entry.

## Test plan
- Step down: target=1000, hyst=50, gain_a=32, pwr_valid with pwr_data=1100, chan 0 -> gain_a=31, spi_dataA=8'h1F, spi_mode=8'h02, channel=0, spi_start one pulse at N+2. Then spi_done at +10 cycles -> busy low after 256 more cycles.
- Dead band: pwr_data=1040 and 960 on chan 1 -> no spi_start, gain_b stays 32, busy high for exactly 1 cycle.
- Saturation: drive gain_b to 63 via repeated low power (pwr_data=0), then one more -> no transaction, sat[1]=1. A subsequent high-power sample clears sat[1], gain_b=62.
- Parallel mode: control_mode=10, pwr_data=1100 -> gain_a decrements, spi_start stays 0, SETTLE entered directly.
- Timeout and drops: spi_done held 0 -> timeout_err=1 after 4096 cycles. Three pwr_valid strobes during WAIT_DONE -> drop_cnt=3.
- Reset mid-WAIT_DONE: assert reset low -> all outputs at reset values the same cycle; after release, gains=32 and FSM is in IDLE.
